// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_pkg: shared constants for the pipeline stall controller slice.
//   MD_IDLE / MD_BUSY   : mul/div occupancy state encoding
//   REG_ZERO            : architectural register $zero (never a real hazard source)
//   MULDIV_LAT_DEFAULT  : default mul/div busy latency in cycles (legal 1..15)
package pipeline_pkg;

    localparam logic       MD_IDLE            = 1'b0;
    localparam logic       MD_BUSY            = 1'b1;
    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MULDIV_LAT_DEFAULT = 4;

endpackage : pipeline_pkg

// File: rtl/pipeline_stall_controller_muldiv_occupancy.sv
// muldiv_occupancy: tracks how long the multi-cycle HI/LO unit stays busy.
// Ports:
//   Clk   - rising-edge clock
//   Rst_n - asynchronous active-low reset (clears state and counter at once)
//   start - a mul/div issues from ID at this edge
//   busy  - unit occupied; decoded straight from the state register
module muldiv_occupancy
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic start,
    output logic busy
);

    logic       state_r;
    logic       state_nxt_s;
    logic [3:0] md_cnt_r;
    logic [3:0] md_cnt_nxt_s;

    // State and occupancy counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r  <= MD_IDLE;
            md_cnt_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
        end
    end

    // Next-state logic. The counter keeps running regardless of pipeline
    // holds because the unit operates independently of the pipeline.
    always_comb begin
        state_nxt_s  = state_r;
        md_cnt_nxt_s = md_cnt_r;
        case (state_r)
            MD_IDLE: begin
                if (start) begin
                    state_nxt_s  = MD_BUSY;
                    md_cnt_nxt_s = 4'(MULDIV_LAT);
                end else begin
                    state_nxt_s  = MD_IDLE;
                    md_cnt_nxt_s = 4'd0;
                end
            end
            MD_BUSY: begin
                // A new start cannot arrive here: the top stalls any mul/div
                // while busy, so only the countdown matters.
                if (md_cnt_r == 4'd1) begin
                    state_nxt_s  = MD_IDLE;
                    md_cnt_nxt_s = 4'd0;
                end else begin
                    state_nxt_s  = MD_BUSY;
                    md_cnt_nxt_s = md_cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s  = MD_IDLE;
                md_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        busy = 1'b0;
        if (state_r == MD_BUSY) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

endmodule : muldiv_occupancy

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: hazard/sequencing control for the 5-stage MIPS
// pipeline. Drives register write enables, IF/ID flush and ID/EX bubble.
// Ports:
//   Clk, Rst_n                 - clock, async active-low reset
//   ID_Rs/ID_Rt, ID_UsesRs/Rt  - ID source registers and whether they are read
//   ID_MulDiv, ID_ReadsHiLo    - ID instruction class for the HI/LO unit
//   EX_MemRead, EX_Rt          - load in EX and its destination
//   EX_Redirect                - taken branch / jump resolved in EX
//   Mem_Wait                   - data memory not ready, freeze everything
//   *_Write                    - pipeline register write enables
//   IFID_Flush, IDEX_Bubble    - NOP insertion controls
//   MD_Busy                    - mul/div unit occupied (registered)
//   Stall_Cycles               - saturating count of cycles ID did not issue
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_MulDiv,
    input  logic        ID_ReadsHiLo,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_Redirect,
    input  logic        Mem_Wait,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Write,
    output logic        EXMEM_Write,
    output logic        MEMWB_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MD_Busy,
    output logic [31:0] Stall_Cycles
);

    logic        lu_s;
    logic        md_s;
    logic        issue_s;
    logic        md_start_s;
    logic [31:0] stall_cnt_r;

    // Hazard terms. A load into $zero never creates a dependency.
    always_comb begin
        lu_s = EX_MemRead && (EX_Rt != REG_ZERO) &&
               ((ID_UsesRs && (ID_Rs == EX_Rt)) || (ID_UsesRt && (ID_Rt == EX_Rt)));
        md_s       = MD_Busy && (ID_MulDiv || ID_ReadsHiLo);
        issue_s    = !Mem_Wait && !EX_Redirect && !lu_s && !md_s;
        // A mul/div that is flushed, stalled or frozen must not start the unit.
        md_start_s = issue_s && ID_MulDiv;
    end

    muldiv_occupancy #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_occupancy (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (md_start_s),
        .busy  (MD_Busy)
    );

    // Priority mux: reset, memory wait, redirect, stall, normal flow.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Write  = 1'b1;
        EXMEM_Write = 1'b1;
        MEMWB_Write = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        if (!Rst_n) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            MEMWB_Write = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (Mem_Wait) begin
            // Freeze: EX is held, so a pending redirect is re-presented later.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            MEMWB_Write = 1'b0;
        end else if (EX_Redirect) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (lu_s || md_s) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            IFID_Flush  = 1'b0;
            IDEX_Bubble = 1'b0;
        end
    end

    // Saturating count of cycles in which ID did not issue.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (!issue_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign Stall_Cycles = stall_cnt_r;

endmodule : pipeline_stall_controller

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the `Write` enables of the PC and the IF/ID and ID/EX pipeline registers, and the flush/bubble controls that zero those registers. It resolves four conditions:

- load-use hazards;
- occupancy of the multi-cycle HI/LO multiply/divide unit;
- taken-branch/jump redirects;
- data-memory wait stalls.

It sits beside the hazard-free datapath and is the only source of those control signals.

## Interface
- `MULDIV_LAT`, default 4: cycles the mul/div unit stays busy after issue; legal range 1..15.
- `Clk` input, 1: rising-edge clock.
- `Rst_n` input, 1: reset, asynchronous, active-low.
- `ID_Rs`, `ID_Rt` input, 5 each: source register numbers of the instruction in ID.
- `ID_UsesRs`, `ID_UsesRt` input, 1 each: ID instruction actually reads that source.
- `ID_MulDiv` input, 1: ID instruction is mult/multu/div/divu.
- `ID_ReadsHiLo` input, 1: ID instruction is mfhi/mflo/mthi/mtlo.
- `EX_MemRead` input, 1: EX instruction is a load.
- `EX_Rt` input, 5: destination of the EX load.
- `EX_Redirect` input, 1: branch taken or jump resolved in EX this cycle.
- `Mem_Wait` input, 1: data memory not ready; the whole pipeline must hold.
- `PC_Write`, `IFID_Write`, `IDEX_Write`, `EXMEM_Write`, `MEMWB_Write` output, 1 each: register write enables.
- `IFID_Flush` output, 1: clear IF/ID to a NOP at the next edge.
- `IDEX_Bubble` output, 1: load a NOP into ID/EX at the next edge.
- `MD_Busy` output, 1: mul/div unit occupied.
- `Stall_Cycles` output, 32: saturating count of cycles in which ID did not issue.

## Operation
**State machine:**
- Two states: `MD_IDLE` and `MD_BUSY`.
- A 4-bit counter `md_cnt` tracks occupancy.
- Reset: state `MD_IDLE`, `md_cnt`=0, `Stall_Cycles`=0.

**Hazard terms:**
- `lu` (load-use) = `EX_MemRead` & (`EX_Rt`≠0) & ((`ID_UsesRs` & `ID_Rs`==`EX_Rt`) | (`ID_UsesRt` & `ID_Rt`==`EX_Rt`)).
- `md` (mul/div hazard) = `MD_Busy` & (`ID_MulDiv` | `ID_ReadsHiLo`).
- `issue` = !`Mem_Wait` & !`EX_Redirect` & !`lu` & !`md`.

**Output priority**, highest first:
1. `Mem_Wait`: all five Write enables 0; `IFID_Flush`=0, `IDEX_Bubble`=0.
2. `EX_Redirect`: all Write enables 1; `IFID_Flush`=1, `IDEX_Bubble`=1. The PC loads the target.
3. `lu` or `md`: `PC_Write`=0, `IFID_Write`=0, `IDEX_Bubble`=1. `IDEX_Write`, `EXMEM_Write` and `MEMWB_Write` are 1.
4. Otherwise: all Write enables 1; flush and bubble 0.

**Mul/div sequencing:**
- When `issue` & `ID_MulDiv`: `md_cnt` loads `MULDIV_LAT` and the state goes to `MD_BUSY`.
- In `MD_BUSY`, `md_cnt` decrements every cycle, including during `Mem_Wait`, because the unit runs independently.
- When `md_cnt`==1 the next state is `MD_IDLE` with `md_cnt`=0.
- `MD_Busy` = (state==`MD_BUSY`), taken from the register. It is not combinational.

**Stall counter:**
- `Stall_Cycles` increments when !`issue`.
- It saturates at 0xFFFF_FFFF.

## Timing
- Hazard-to-control latency is 0: all enables and flush/bubble are combinational from the inputs and registered state.
- A mul/div issued at edge t has `MD_Busy` high for cycles t+1 .. t+`MULDIV_LAT`, and low from t+`MULDIV_LAT`+1.
- A dependent mfhi in ID issues in the first cycle with `MD_Busy`=0.
- A load-use stall lasts exactly 1 cycle: after the bubble, `EX_MemRead` drops.
- Simultaneous `EX_Redirect` and `lu`/`md`: the redirect wins; the stalled ID instruction is flushed. An `ID_MulDiv` in ID at that moment does not start the unit.
- Simultaneous `Mem_Wait` and `EX_Redirect`: freeze. EX is held, so the redirect is re-presented after the wait.
- An `ID_MulDiv` that arrives exactly when `md_cnt`==1 is still stalled that cycle and issues the next cycle.
- While `Rst_n` is low:
  - all Write enables 0;
  - `IFID_Flush`=1, `IDEX_Bubble`=1;
  - `MD_Busy`=0, `Stall_Cycles`=0.
- Asserting reset mid-`MD_BUSY` clears the state immediately.

## Structure
- Shared package `pipeline_pkg`:
  - state encoding constants `MD_IDLE`=1'b0, `MD_BUSY`=1'b1;
  - register-zero constant `REG_ZERO`=5'd0;
  - the `MULDIV_LAT` default.
- Sub-module `muldiv_occupancy`: the state machine plus `md_cnt`, with inputs `start` and outputs `busy`. The top keeps the hazard terms, the priority mux and `Stall_Cycles`.

## Test plan
- Load $t1 with `EX_MemRead`=1, `EX_Rt`=9; ID add with `ID_Rs`=9, `ID_UsesRs`=1 → one cycle of `PC_Write`=0, `IFID_Write`=0, `IDEX_Bubble`=1; `Stall_Cycles`=1.
- Same as above with `EX_Rt`=0 (loading $zero) → no stall; all Write enables 1.
- mult issued at edge t, `MULDIV_LAT`=4, mflo held in ID → `MD_Busy` high cycles t+1..t+4; mflo stalled 4 cycles, issues at t+5; `Stall_Cycles`=4.
- `EX_Redirect`=1 together with `lu`=1 → `IFID_Flush`=1, `IDEX_Bubble`=1, `PC_Write`=1.
- `Mem_Wait`=1 for 3 cycles during `MD_BUSY` with `md_cnt`=3 → all enables 0 for 3 cycles; `MD_Busy` falls after the 3rd edge.
- `Rst_n` pulsed low mid-`MD_BUSY` → `MD_Busy`=0 and `Stall_Cycles`=0 immediately; flush and bubble asserted until release.
